// File: rtl/ncal_pkg.sv
// Shared bus constants and FSM state type for the NCAL host master.
package ncal_pkg;

  localparam logic [31:0] CFG_REG_A = 32'h0000_0000;
  localparam logic [31:0] CALT_A    = 32'h0000_0001;
  localparam logic [31:0] START_A   = 32'h0000_0002;
  localparam logic [31:0] CMEM_BASE = 32'h0002_0000;
  localparam logic [31:0] DMEM_BASE = 32'h0004_0000;
  localparam logic [31:0] START_KEY = 32'h0000_0ACE;

  typedef enum logic [3:0] {
    IDLE, LD_CFG, LD_DAT, WR_CFGR, WR_CALT, WR_START,
    WAIT_PUSH, RD_ADDR, RD_WAIT, RD_OUT, FIN
  } state_t;

  // Where the job goes once the config-memory load is finished (or skipped).
  function automatic state_t load_exit(input logic [15:0] dat_words);
    if (dat_words != 16'd0) return LD_DAT;
    return WR_CFGR;
  endfunction

endpackage

// File: rtl/ncal_tmo_ctr.sv
// Wait-for-pushout timer: counts enabled cycles, pulses expire on the last allowed one.
module ncal_tmo_ctr #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else if (enable)    count <= count + W'(1);
  end

  // A zero limit disables the timeout entirely.
  assign expire = enable && (limit != '0) && (count == limit - W'(1));

endmodule

// File: rtl/ncal_host_master.sv
// NCAL host master: loads engine memories, writes the control registers,
// waits for pushout and streams the result words back out.
//
// state     | meaning
// IDLE      | waiting for go
// LD_CFG    | streaming load words into config memory
// LD_DAT    | streaming load words into data memory
// WR_CFGR   | writing config register
// WR_CALT   | writing cal-time register
// WR_START  | writing start key
// WAIT_PUSH | waiting for pushout or timeout
// RD_ADDR   | first cycle of a result read
// RD_WAIT   | holding the read address until dout is valid
// RD_OUT    | presenting a result word on the output stream
// FIN       | one-cycle done pulse
module ncal_host_master
  import ncal_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int TMO_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [15:0]      cfg_words,
  input  logic [15:0]      dat_words,
  input  logic [31:0]      config_val,
  input  logic [31:0]      cal_time,
  input  logic [TMO_W-1:0] tmo_limit,
  input  logic [16:0]      res_base,
  input  logic [15:0]      res_words,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             sel,
  output logic             RW,
  output logic [31:0]      addr,
  output logic [31:0]      din,
  input  logic [31:0]      dout,
  input  logic             pushout,
  input  logic             bus_stop,
  output logic             busy,
  output logic             done,
  output logic             err_tmo
);

  state_t      state, next_state;
  logic [15:0] k, j, wcnt;
  logic        tmo_exp;
  logic        unused_bus_stop;

  assign unused_bus_stop = bus_stop;

  ncal_tmo_ctr #(.W(TMO_W)) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != WAIT_PUSH),
    .enable (state == WAIT_PUSH),
    .limit  (tmo_limit),
    .expire (tmo_exp)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (go) next_state = (cfg_words != 16'd0) ? LD_CFG : load_exit(dat_words);
      LD_CFG:    if (in_valid && (k == cfg_words - 16'd1)) next_state = load_exit(dat_words);
      LD_DAT:    if (in_valid && (k == dat_words - 16'd1)) next_state = WR_CFGR;
      WR_CFGR:   next_state = WR_CALT;
      WR_CALT:   next_state = WR_START;
      WR_START:  next_state = WAIT_PUSH;
      WAIT_PUSH: begin
        if (pushout)      next_state = (res_words == 16'd0) ? FIN : RD_ADDR;
        else if (tmo_exp) next_state = FIN;
      end
      RD_ADDR:   next_state = (RD_LAT == 0) ? RD_OUT : RD_WAIT;
      RD_WAIT:   if (wcnt == 16'(RD_LAT - 1)) next_state = RD_OUT;
      RD_OUT:    if (out_ready) next_state = (j + 16'd1 == res_words) ? FIN : RD_ADDR;
      FIN:       next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k        <= '0;
      j        <= '0;
      wcnt     <= '0;
      out_data <= '0;
      err_tmo  <= 1'b0;
    end else begin
      // pushout has priority over an expiring timer in the same cycle
      if (state == IDLE && go) err_tmo <= 1'b0;
      if (state == WAIT_PUSH && !pushout && tmo_exp) err_tmo <= 1'b1;
      case (state)
        IDLE: begin
          k <= '0;
          j <= '0;
        end
        LD_CFG:  if (in_valid) k <= (k == cfg_words - 16'd1) ? 16'd0 : k + 16'd1;
        LD_DAT:  if (in_valid) k <= (k == dat_words - 16'd1) ? 16'd0 : k + 16'd1;
        RD_ADDR: begin
          wcnt <= '0;
          if (RD_LAT == 0) out_data <= dout;
        end
        RD_WAIT: begin
          wcnt <= wcnt + 16'd1;
          if (wcnt == 16'(RD_LAT - 1)) out_data <= dout;
        end
        RD_OUT:  if (out_ready) j <= j + 16'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    sel       = 1'b0;
    RW        = 1'b0;
    addr      = '0;
    din       = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      LD_CFG, LD_DAT: begin
        in_ready = 1'b1;
        sel      = in_valid;
        RW       = in_valid;
        addr     = ((state == LD_CFG) ? CMEM_BASE : DMEM_BASE) + {16'h0, k};
        din      = in_data;
      end
      WR_CFGR:  begin sel = 1'b1; RW = 1'b1; addr = CFG_REG_A; din = config_val; end
      WR_CALT:  begin sel = 1'b1; RW = 1'b1; addr = CALT_A;    din = cal_time;   end
      WR_START: begin sel = 1'b1; RW = 1'b1; addr = START_A;   din = START_KEY;  end
      RD_ADDR, RD_WAIT: begin
        sel  = 1'b1;
        addr = DMEM_BASE + {15'h0, res_base} + {16'h0, j};
      end
      RD_OUT:   out_valid = 1'b1;
      FIN:      done = 1'b1;
      default:  ;
    endcase
  end

endmodule
